// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int MD_LATENCY_DEF = 4;

endpackage

// File: rtl/pipeline_ctrl_md_timer.sv
// Mul/div countdown: loaded at the start cycle, decremented while waiting,
// and flags the final wait cycle (count == 1).
module md_timer #(
  parameter int CNT_W      = 8,
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CNT_W'(MD_LATENCY - 1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller: forwarding selects, load-use stall, branch flush and
// mul/div freeze sequencing. Perf counters exist only with PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  ResultSrcE0,
  input  logic                  PCSrcE,
  input  logic                  MulDivStartE,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] RdW,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  MdDoneE,
  output logic [31:0]           StallCycles,
  output logic [31:0]           FlushCount
);

  ctrl_state_t state_q, state_d;
  logic        lw_stall;
  logic        md_load;
  logic        md_dec;
  logic        md_last;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      return FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    state_d   = state_q;
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
    StallF    = lw_stall;
    StallD    = lw_stall;
    StallE    = 1'b0;
    FlushD    = PCSrcE;
    FlushE    = lw_stall || PCSrcE;
    FlushM    = 1'b0;
    MdDoneE   = 1'b0;
    md_load   = 1'b0;
    md_dec    = 1'b0;

    case (state_q)
      RUN: begin
        if (MulDivStartE) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          md_load = 1'b1;
          state_d = (MD_LATENCY >= 2) ? MD_WAIT : MD_DONE;
        end
      end
      MD_WAIT: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
        FlushD = 1'b0;
        FlushE = 1'b0;
        md_dec = 1'b1;
        if (md_last) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: begin
        // The mul/div instruction is leaving E, so its start strobe is stale.
        MdDoneE = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (!rst_n) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      MdDoneE   = 1'b0;
      md_load   = 1'b0;
      md_dec    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  md_timer #(
    .CNT_W      (CNT_W),
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (md_load),
    .dec_i  (md_dec),
    .last_o (md_last)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (PCSrcE) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule
